// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM; Moore outputs (FETCH irwrite/pcen and BEQEX/BNEEX pcen follow inputs).
// Latency LW 5, SW/R/ADDI 4, BEQ/J 3 cycles; memready=0 holds FETCH/MEMRD/MEMWR. Define BNE_SUPPORT_EN for BNE.
module mips_multicycle_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       memready,
    output logic       memreq,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [2:0] alucontrol,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic       illegal,
    output logic [3:0] state
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;
`ifdef BNE_SUPPORT_EN
    localparam logic [5:0] OP_BNE   = 6'h05;
`endif

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
`ifdef BNE_SUPPORT_EN
        , S_BNEEX = 4'd12
`endif
    } state_t;

    state_t cur_state, nxt_state;
    // Load/store choice is captured in DECODE so MEMADR never looks at op.
    logic   is_sw, is_sw_nxt;

    logic memreq_s, memwrite_s, irwrite_s, regwrite_s, pcen_s, illegal_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= S_FETCH;
            is_sw     <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            is_sw     <= is_sw_nxt;
        end
    end

    always_comb begin
        nxt_state  = S_FETCH;
        is_sw_nxt  = is_sw;
        memreq_s   = 1'b0;
        memwrite_s = 1'b0;
        irwrite_s  = 1'b0;
        regwrite_s = 1'b0;
        pcen_s     = 1'b0;
        illegal_s  = 1'b0;
        iord       = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        alucontrol = 3'd0;
        pcsrc      = 2'b00;

        case (cur_state)
            S_FETCH: begin
                memreq_s   = 1'b1;
                alusrcb    = 2'b01;
                alucontrol = 3'd2;
                irwrite_s  = memready;
                pcen_s     = memready;
                nxt_state  = memready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alusrcb    = 2'b11;
                alucontrol = 3'd2;
                case (op)
                    OP_LW: begin
                        nxt_state = S_MEMADR;
                        is_sw_nxt = 1'b0;
                    end
                    OP_SW: begin
                        nxt_state = S_MEMADR;
                        is_sw_nxt = 1'b1;
                    end
                    OP_RTYPE: nxt_state = S_RTYPEEX;
                    OP_BEQ:   nxt_state = S_BEQEX;
                    OP_ADDI:  nxt_state = S_ADDIEX;
                    OP_J:     nxt_state = S_JEX;
`ifdef BNE_SUPPORT_EN
                    OP_BNE:   nxt_state = S_BNEEX;
`endif
                    default: begin
                        illegal_s = 1'b1;
                        nxt_state = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = 3'd2;
                nxt_state  = is_sw ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                memreq_s  = 1'b1;
                iord      = 1'b1;
                nxt_state = memready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                memtoreg   = 1'b1;
                regwrite_s = 1'b1;
            end
            S_MEMWR: begin
                memreq_s   = 1'b1;
                iord       = 1'b1;
                memwrite_s = 1'b1;
                nxt_state  = memready ? S_FETCH : S_MEMWR;
            end
            S_RTYPEEX: begin
                alusrca   = 1'b1;
                nxt_state = S_RTYPEWB;
                case (funct)
                    6'h20:   alucontrol = 3'd2;
                    6'h22:   alucontrol = 3'd6;
                    6'h24:   alucontrol = 3'd0;
                    6'h25:   alucontrol = 3'd1;
                    6'h2A:   alucontrol = 3'd7;
                    default: begin
                        alucontrol = 3'd2;
                        illegal_s  = 1'b1;
                        nxt_state  = S_FETCH;
                    end
                endcase
            end
            S_RTYPEWB: begin
                regdst     = 1'b1;
                regwrite_s = 1'b1;
            end
            S_BEQEX: begin
                alusrca    = 1'b1;
                alucontrol = 3'd6;
                pcsrc      = 2'b01;
                pcen_s     = zero;
            end
`ifdef BNE_SUPPORT_EN
            S_BNEEX: begin
                alusrca    = 1'b1;
                alucontrol = 3'd6;
                pcsrc      = 2'b01;
                pcen_s     = ~zero;
            end
`endif
            S_ADDIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = 3'd2;
                nxt_state  = S_ADDIWB;
            end
            S_ADDIWB: regwrite_s = 1'b1;
            S_JEX: begin
                pcsrc  = 2'b10;
                pcen_s = 1'b1;
            end
            default: nxt_state = S_FETCH;
        endcase
    end

    // Enables are gated by rst_n directly so an abandoned write drops without waiting for a clock.
    assign memreq   = memreq_s   & rst_n;
    assign memwrite = memwrite_s & rst_n;
    assign irwrite  = irwrite_s  & rst_n;
    assign regwrite = regwrite_s & rst_n;
    assign pcen     = pcen_s     & rst_n;
    assign illegal  = illegal_s  & rst_n;
    assign state    = cur_state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: inputs change on the falling edge, outputs compared 1 time unit later.
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       memready;
    logic       memreq, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb;
    logic [2:0] alucontrol;
    logic [1:0] pcsrc;
    logic       pcen, illegal;
    logic [3:0] state;

    int passed = 0;
    int checks = 0;

    mips_multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .memready(memready),
        .memreq(memreq), .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
        .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
        .alucontrol(alucontrol), .pcsrc(pcsrc), .pcen(pcen), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    // Field order: memreq iord memwrite irwrite regdst memtoreg regwrite alusrca alusrcb alucontrol pcsrc pcen illegal state
    logic [20:0] ctl;
    assign ctl = {memreq, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                  alusrcb, alucontrol, pcsrc, pcen, illegal, state};

    localparam logic [20:0] W_RESET      = {7'b0000000, 1'b0, 2'b01, 3'd2, 2'b00, 1'b0, 1'b0, 4'd0};
    localparam logic [20:0] W_FETCH      = {7'b1001000, 1'b0, 2'b01, 3'd2, 2'b00, 1'b1, 1'b0, 4'd0};
    localparam logic [20:0] W_FETCH_STL  = {7'b1000000, 1'b0, 2'b01, 3'd2, 2'b00, 1'b0, 1'b0, 4'd0};
    localparam logic [20:0] W_DECODE     = {7'b0000000, 1'b0, 2'b11, 3'd2, 2'b00, 1'b0, 1'b0, 4'd1};
    localparam logic [20:0] W_DECODE_ILL = {7'b0000000, 1'b0, 2'b11, 3'd2, 2'b00, 1'b0, 1'b1, 4'd1};
    localparam logic [20:0] W_MEMADR     = {7'b0000000, 1'b1, 2'b10, 3'd2, 2'b00, 1'b0, 1'b0, 4'd2};
    localparam logic [20:0] W_MEMRD      = {7'b1100000, 1'b0, 2'b00, 3'd0, 2'b00, 1'b0, 1'b0, 4'd3};
    localparam logic [20:0] W_MEMWB      = {7'b0000011, 1'b0, 2'b00, 3'd0, 2'b00, 1'b0, 1'b0, 4'd4};
    localparam logic [20:0] W_MEMWR      = {7'b1110000, 1'b0, 2'b00, 3'd0, 2'b00, 1'b0, 1'b0, 4'd5};
    localparam logic [20:0] W_RTYPEWB    = {7'b0000101, 1'b0, 2'b00, 3'd0, 2'b00, 1'b0, 1'b0, 4'd7};
    localparam logic [20:0] W_ADDIEX     = {7'b0000000, 1'b1, 2'b10, 3'd2, 2'b00, 1'b0, 1'b0, 4'd9};
    localparam logic [20:0] W_ADDIWB     = {7'b0000001, 1'b0, 2'b00, 3'd0, 2'b00, 1'b0, 1'b0, 4'd10};
    localparam logic [20:0] W_JEX        = {7'b0000000, 1'b0, 2'b00, 3'd0, 2'b10, 1'b1, 1'b0, 4'd11};

    function automatic logic [20:0] w_rtex(input logic [2:0] alu, input logic ill);
        return {7'b0000000, 1'b1, 2'b00, alu, 2'b00, 1'b0, ill, 4'd6};
    endfunction

    function automatic logic [20:0] w_branch(input logic pc_en, input logic [3:0] st);
        return {7'b0000000, 1'b1, 2'b00, 3'd6, 2'b01, pc_en, 1'b0, st};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; memready = 1'b1; op = 6'h00; funct = 6'h20; zero = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if (ctl !== W_RESET) $display("FAIL reset cycle %0d: got %h expected %h", c, ctl, W_RESET);
            else passed++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (ctl !== W_FETCH) $display("FAIL first_fetch: got %h expected %h", ctl, W_FETCH);
        else passed++;
    endtask

    task automatic test_rtype();
        logic [5:0]  fn [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        logic [2:0]  al [5] = '{3'd2, 3'd6, 3'd0, 3'd1, 3'd7};
        logic [20:0] exp [4];
        for (int i = 0; i < 5; i++) begin
            exp = '{W_FETCH, W_DECODE, w_rtex(al[i], 1'b0), W_RTYPEWB};
            op = 6'h00; funct = fn[i]; memready = 1'b1;
            for (int c = 0; c < 4; c++) begin
                #1;
                checks++;
                if (ctl !== exp[c]) $display("FAIL rtype funct=%h cycle %0d: got %h expected %h", fn[i], c, ctl, exp[c]);
                else passed++;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_lw_stall();
        logic [20:0] exp [7] = '{W_FETCH, W_DECODE, W_MEMADR, W_MEMRD, W_MEMRD, W_MEMRD, W_MEMWB};
        logic        mr  [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        op = 6'h23; funct = 6'h00;
        for (int c = 0; c < 7; c++) begin
            memready = mr[c];
            #1;
            checks++;
            if (ctl !== exp[c]) $display("FAIL lw_stall cycle %0d: got %h expected %h", c, ctl, exp[c]);
            else passed++;
            @(negedge clk);
        end
    endtask

    task automatic test_sw_fetch_stall();
        logic [20:0] exp [5] = '{W_FETCH_STL, W_FETCH, W_DECODE, W_MEMADR, W_MEMWR};
        logic        mr  [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        op = 6'h2B; funct = 6'h00;
        for (int c = 0; c < 5; c++) begin
            memready = mr[c];
            #1;
            checks++;
            if (ctl !== exp[c]) $display("FAIL sw cycle %0d: got %h expected %h", c, ctl, exp[c]);
            else passed++;
            @(negedge clk);
        end
    endtask

    task automatic test_beq();
        logic [20:0] exp [3];
        for (int z = 1; z >= 0; z--) begin
            exp = '{W_FETCH, W_DECODE, w_branch(z[0], 4'd8)};
            op = 6'h04; funct = 6'h00; zero = z[0]; memready = 1'b1;
            for (int c = 0; c < 3; c++) begin
                #1;
                checks++;
                if (ctl !== exp[c]) $display("FAIL beq zero=%0d cycle %0d: got %h expected %h", z, c, ctl, exp[c]);
                else passed++;
                @(negedge clk);
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_addi_j();
        logic [20:0] exp [7] = '{W_FETCH, W_DECODE, W_ADDIEX, W_ADDIWB, W_FETCH, W_DECODE, W_JEX};
        memready = 1'b1; funct = 6'h00;
        for (int c = 0; c < 7; c++) begin
            op = (c < 4) ? 6'h08 : 6'h02;
            #1;
            checks++;
            if (ctl !== exp[c]) $display("FAIL addi_j cycle %0d: got %h expected %h", c, ctl, exp[c]);
            else passed++;
            @(negedge clk);
        end
    endtask

    task automatic test_illegal();
        logic [20:0] exp_op [3] = '{W_FETCH, W_DECODE_ILL, W_FETCH_STL};
        logic [20:0] exp_fn [4] = '{W_FETCH, W_DECODE, w_rtex(3'd2, 1'b1), W_FETCH_STL};
        op = 6'h3F; funct = 6'h20;
        for (int c = 0; c < 3; c++) begin
            memready = (c == 2) ? 1'b0 : 1'b1;
            #1;
            checks++;
            if (ctl !== exp_op[c]) $display("FAIL illegal_op cycle %0d: got %h expected %h", c, ctl, exp_op[c]);
            else passed++;
            @(negedge clk);
        end
        op = 6'h00; funct = 6'h00;
        for (int c = 0; c < 4; c++) begin
            memready = (c == 3) ? 1'b0 : 1'b1;
            #1;
            checks++;
            if (ctl !== exp_fn[c]) $display("FAIL illegal_funct cycle %0d: got %h expected %h", c, ctl, exp_fn[c]);
            else passed++;
            @(negedge clk);
        end
    endtask

    task automatic test_bne_op();
`ifdef BNE_SUPPORT_EN
        logic [20:0] exp [3] = '{W_FETCH, W_DECODE, w_branch(1'b1, 4'd12)};
`else
        logic [20:0] exp [3] = '{W_FETCH, W_DECODE_ILL, W_FETCH_STL};
`endif
        op = 6'h05; funct = 6'h00; zero = 1'b0;
        for (int c = 0; c < 3; c++) begin
            memready = (c == 2) ? 1'b0 : 1'b1;
            #1;
            checks++;
            if (ctl !== exp[c]) $display("FAIL bne_op cycle %0d: got %h expected %h", c, ctl, exp[c]);
            else passed++;
            @(negedge clk);
        end
`ifdef BNE_SUPPORT_EN
        memready = 1'b0;
        #1;
        checks++;
        if (ctl !== W_FETCH_STL) $display("FAIL bne_return: got %h expected %h", ctl, W_FETCH_STL);
        else passed++;
        @(negedge clk);
`endif
    endtask

    task automatic test_reset_mid_store();
        logic [20:0] exp [4] = '{W_FETCH, W_DECODE, W_MEMADR, W_MEMWR};
        op = 6'h2B; funct = 6'h00;
        for (int c = 0; c < 4; c++) begin
            memready = (c == 3) ? 1'b0 : 1'b1;
            #1;
            checks++;
            if (ctl !== exp[c]) $display("FAIL mid_store cycle %0d: got %h expected %h", c, ctl, exp[c]);
            else passed++;
            if (c < 3) @(negedge clk);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (ctl !== W_RESET) $display("FAIL mid_store_reset: got %h expected %h", ctl, W_RESET);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1; memready = 1'b1;
        #1;
        checks++;
        if (ctl !== W_FETCH) $display("FAIL mid_store_refetch: got %h expected %h", ctl, W_FETCH);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_stall();
        test_sw_fetch_stall();
        test_beq();
        test_addi_j();
        test_illegal();
        test_bne_op();
        test_reset_mid_store();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
